// File: rtl/obi_amo_sequencer_pkg.sv
// Shared definitions for the OBI atomics sequencer.
//   obi_atop_e  : OBI atomic opcode encoding (6 bits, AMONONE = plain access)
//   is_rmw_op() : true for opcodes that are resolved as read-modify-write
package obi_amo_sequencer_pkg;

    typedef enum logic [5:0] {
        AMONONE = 6'h00,
        AMOADD  = 6'h20,
        AMOSWAP = 6'h21,
        AMOLR   = 6'h22,
        AMOSC   = 6'h23,
        AMOXOR  = 6'h24,
        AMOOR   = 6'h28,
        AMOAND  = 6'h2C,
        AMOMIN  = 6'h30,
        AMOMAX  = 6'h34,
        AMOMINU = 6'h38,
        AMOMAXU = 6'h3C
    } obi_atop_e;

    function automatic logic is_rmw_op(input logic [5:0] atop);
        case (atop)
            AMOADD, AMOSWAP, AMOXOR, AMOOR, AMOAND,
            AMOMIN, AMOMAX, AMOMINU, AMOMAXU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/obi_amo_alu.sv
// Combinational AMO modify step: new_val = op(old, operand).
//   atop     in  6          atomic opcode (obi_atop_e encoding)
//   old      in  DataWidth  value read from memory
//   operand  in  DataWidth  operand from the request
//   new_val  out DataWidth  value to write back
// Opcodes without a modify step (LR/SC/unknown) yield the operand unchanged,
// which is exactly the store-conditional write value.
module obi_amo_alu
    import obi_amo_sequencer_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic [5:0]           atop,
    input  logic [DataWidth-1:0] old,
    input  logic [DataWidth-1:0] operand,
    output logic [DataWidth-1:0] new_val
);

    always_comb begin
        new_val = operand;
        case (atop)
            AMOADD:  new_val = old + operand;
            AMOXOR:  new_val = old ^ operand;
            AMOAND:  new_val = old & operand;
            AMOOR:   new_val = old | operand;
            AMOMIN:  new_val = ($signed(old) < $signed(operand)) ? old : operand;
            AMOMAX:  new_val = ($signed(old) > $signed(operand)) ? old : operand;
            AMOMINU: new_val = (old < operand) ? old : operand;
            AMOMAXU: new_val = (old > operand) ? old : operand;
            default: new_val = operand;
        endcase
    end

endmodule

// File: rtl/obi_amo_sequencer.sv
// OBI atomics sequencer: resolves AMOs for a subordinate without native
// atomics. Plain accesses pass straight through in IDLE; AMOs are granted
// immediately and replayed downstream as read + modify + write.
// At most one transaction is outstanding.
// Ports:
//   clk_i, rst_i (synchronous, active-high)
//   sbr_*  upstream OBI subordinate port (req/gnt/addr/we/be/wdata/atop, rvalid/rdata/err)
//   mgr_*  downstream OBI manager port   (req/gnt/addr/we/be/wdata, rvalid/rdata/err)
// Configuration macro: OBI_AMO_SEQ_LRSC_EN enables LR/SC with one reservation;
// without it LR/SC are answered as illegal opcodes.
module obi_amo_sequencer
    import obi_amo_sequencer_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   sbr_req_i,
    output logic                   sbr_gnt_o,
    input  logic [AddrWidth-1:0]   sbr_addr_i,
    input  logic                   sbr_we_i,
    input  logic [DataWidth/8-1:0] sbr_be_i,
    input  logic [DataWidth-1:0]   sbr_wdata_i,
    input  logic [5:0]             sbr_atop_i,
    output logic                   sbr_rvalid_o,
    output logic [DataWidth-1:0]   sbr_rdata_o,
    output logic                   sbr_err_o,
    output logic                   mgr_req_o,
    input  logic                   mgr_gnt_i,
    output logic [AddrWidth-1:0]   mgr_addr_o,
    output logic                   mgr_we_o,
    output logic [DataWidth/8-1:0] mgr_be_o,
    output logic [DataWidth-1:0]   mgr_wdata_o,
    input  logic                   mgr_rvalid_i,
    input  logic [DataWidth-1:0]   mgr_rdata_i,
    input  logic                   mgr_err_i
);

    typedef enum logic [2:0] {
        IDLE, PASS_WAIT, AMO_RD, AMO_RD_WAIT, AMO_WR, AMO_WR_WAIT, RESP
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] operand_q;
    logic [DataWidth-1:0] rdata_q;   // old value, SC status or 0, returned in RESP
    logic [5:0]           atop_q;
    logic                 err_q;
    logic [DataWidth-1:0] alu_res;

    logic rmw_op, lr_op, sc_op, resv_match, amo_accept;

    assign rmw_op     = is_rmw_op(sbr_atop_i);
    assign amo_accept = (state_q == IDLE) && sbr_req_i && (sbr_atop_i != AMONONE);

`ifdef OBI_AMO_SEQ_LRSC_EN
    logic                 resv_valid_q;
    logic [AddrWidth-3:0] resv_addr_q;   // word address

    assign lr_op      = (sbr_atop_i == AMOLR);
    assign sc_op      = (sbr_atop_i == AMOSC);
    assign resv_match = resv_valid_q && (resv_addr_q == sbr_addr_i[AddrWidth-1:2]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
        end else if (state_q == AMO_RD_WAIT && mgr_rvalid_i && !mgr_err_i && atop_q == AMOLR) begin
            resv_valid_q <= 1'b1;
            resv_addr_q  <= addr_q[AddrWidth-1:2];
        end else if (state_q == IDLE && sbr_atop_i == AMONONE && sbr_req_i && mgr_gnt_i
                     && sbr_we_i && resv_match) begin
            resv_valid_q <= 1'b0;
        end else if (amo_accept && sc_op) begin
            resv_valid_q <= 1'b0;   // SC consumes the reservation whatever the outcome
        end else if (state_q == AMO_WR && mgr_gnt_i
                     && resv_addr_q == addr_q[AddrWidth-1:2]) begin
            resv_valid_q <= 1'b0;
        end
    end
`else
    assign lr_op      = 1'b0;
    assign sc_op      = 1'b0;
    assign resv_match = 1'b0;
`endif

    obi_amo_alu #(.DataWidth(DataWidth)) u_alu (
        .atop    (atop_q),
        .old     (rdata_q),
        .operand (operand_q),
        .new_val (alu_res)
    );

    always_comb begin
        state_d      = state_q;
        sbr_gnt_o    = 1'b0;
        mgr_req_o    = 1'b0;
        mgr_addr_o   = addr_q;
        mgr_we_o     = 1'b0;
        mgr_be_o     = '1;
        mgr_wdata_o  = alu_res;
        sbr_rvalid_o = 1'b0;
        sbr_rdata_o  = rdata_q;
        sbr_err_o    = err_q;
        case (state_q)
            IDLE: begin
                if (sbr_atop_i == AMONONE) begin
                    mgr_req_o   = sbr_req_i;
                    mgr_addr_o  = sbr_addr_i;
                    mgr_we_o    = sbr_we_i;
                    mgr_be_o    = sbr_be_i;
                    mgr_wdata_o = sbr_wdata_i;
                    sbr_gnt_o   = mgr_gnt_i;
                    if (sbr_req_i && mgr_gnt_i) state_d = PASS_WAIT;
                end else if (sbr_req_i) begin
                    sbr_gnt_o = 1'b1;
                    if (rmw_op || lr_op)        state_d = AMO_RD;
                    else if (sc_op && resv_match) state_d = AMO_WR;  // SC needs no read
                    else                        state_d = RESP;    // failed SC or illegal
                end
            end
            PASS_WAIT: begin
                sbr_rvalid_o = mgr_rvalid_i;
                sbr_rdata_o  = mgr_rdata_i;
                sbr_err_o    = mgr_err_i;
                if (mgr_rvalid_i) state_d = IDLE;
            end
            AMO_RD: begin
                mgr_req_o = 1'b1;
                if (mgr_gnt_i) state_d = AMO_RD_WAIT;
            end
            AMO_RD_WAIT: begin
                if (mgr_rvalid_i)
                    state_d = (mgr_err_i || atop_q == AMOLR) ? RESP : AMO_WR;
            end
            AMO_WR: begin
                mgr_req_o = 1'b1;
                mgr_we_o  = 1'b1;
                if (mgr_gnt_i) state_d = AMO_WR_WAIT;
            end
            AMO_WR_WAIT: begin
                if (mgr_rvalid_i) state_d = RESP;
            end
            RESP: begin
                sbr_rvalid_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            sbr_gnt_o    = 1'b0;
            mgr_req_o    = 1'b0;
            sbr_rvalid_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            operand_q <= '0;
            rdata_q   <= '0;
            atop_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (amo_accept) begin
                addr_q    <= sbr_addr_i;
                operand_q <= sbr_wdata_i;
                atop_q    <= sbr_atop_i;
                rdata_q   <= '0;
                err_q     <= 1'b0;
                if (sc_op)                    rdata_q <= {{(DataWidth-1){1'b0}}, !resv_match};
                else if (!rmw_op && !lr_op)   err_q   <= 1'b1;
            end
            if (state_q == AMO_RD_WAIT && mgr_rvalid_i) begin
                rdata_q <= mgr_rdata_i;
                err_q   <= mgr_err_i;
            end
            if (state_q == AMO_WR_WAIT && mgr_rvalid_i) err_q <= mgr_err_i;
        end
    end

endmodule

// File: tb/tb_obi_amo_sequencer.sv
module tb_obi_amo_sequencer;

    localparam logic [5:0] A_NONE = 6'h00, A_ADD = 6'h20, A_SWAP = 6'h21, A_LR = 6'h22,
                           A_SC = 6'h23, A_XOR = 6'h24, A_OR = 6'h28, A_AND = 6'h2C,
                           A_MIN = 6'h30, A_MAX = 6'h34, A_MINU = 6'h38, A_MAXU = 6'h3C;
`ifdef OBI_AMO_SEQ_LRSC_EN
    localparam bit LRSC = 1'b1;
`else
    localparam bit LRSC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sbr_req, sbr_gnt, sbr_we, sbr_rvalid, sbr_err;
    logic [31:0] sbr_addr, sbr_wdata, sbr_rdata;
    logic [3:0]  sbr_be;
    logic [5:0]  sbr_atop;
    logic        mgr_req, mgr_gnt, mgr_we, mgr_rvalid, mgr_err;
    logic [31:0] mgr_addr, mgr_wdata, mgr_rdata;
    logic [3:0]  mgr_be;

    obi_amo_sequencer dut (
        .clk_i(clk), .rst_i(rst),
        .sbr_req_i(sbr_req), .sbr_gnt_o(sbr_gnt), .sbr_addr_i(sbr_addr), .sbr_we_i(sbr_we),
        .sbr_be_i(sbr_be), .sbr_wdata_i(sbr_wdata), .sbr_atop_i(sbr_atop),
        .sbr_rvalid_o(sbr_rvalid), .sbr_rdata_o(sbr_rdata), .sbr_err_o(sbr_err),
        .mgr_req_o(mgr_req), .mgr_gnt_i(mgr_gnt), .mgr_addr_o(mgr_addr), .mgr_we_o(mgr_we),
        .mgr_be_o(mgr_be), .mgr_wdata_o(mgr_wdata),
        .mgr_rvalid_i(mgr_rvalid), .mgr_rdata_i(mgr_rdata), .mgr_err_i(mgr_err)
    );

    int checks = 0, passed = 0, fails = 0;
    int n_rd, n_wr, req_cycles;
    bit inject_rd_err;
    logic [31:0] mem     [bit [29:0]];   // downstream memory
    logic [31:0] ref_mem [bit [29:0]];   // reference view
    bit          rsv_v;
    bit   [29:0] rsv_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input bit [29:0] w);
        return mem.exists(w) ? mem[w] : 32'h0;
    endfunction
    function automatic logic [31:0] rd_ref(input bit [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Downstream memory: random grant, response one cycle after handshake.
    initial begin
        logic        pend = 1'b0, pend_err = 1'b0;
        logic [31:0] pend_data = 32'h0;
        mgr_gnt = 1'b0; mgr_rvalid = 1'b0; mgr_rdata = 32'h0; mgr_err = 1'b0;
        forever begin
            @(negedge clk);
            mgr_rvalid = pend; mgr_rdata = pend_data; mgr_err = pend_err;
            pend = 1'b0;
            mgr_gnt = rst ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            if (mgr_req) req_cycles++;
            if (mgr_req && mgr_gnt) begin
                if (mgr_we) begin
                    n_wr++;
                    mem[mgr_addr[31:2]] = merge(rd_mem(mgr_addr[31:2]), mgr_be, mgr_wdata);
                    pend_data = 32'h0; pend_err = 1'b0;
                end else begin
                    n_rd++;
                    pend_data = rd_mem(mgr_addr[31:2]);
                    pend_err = inject_rd_err;
                    inject_rd_err = 1'b0;
                end
                pend = 1'b1;
            end
        end
    end

    // Reference: the effect of one upstream transaction as a whole.
    task automatic model(input logic we, input logic [5:0] atop, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input bit rerr,
                         output logic [31:0] x_rdata, output logic x_err,
                         output int x_rd, output int x_wr, output bit x_chk);
        bit [29:0]   w   = addr[31:2];
        logic [31:0] old = rd_ref(w);
        logic [31:0] nv;
        bit          hit = rsv_v && (rsv_a == w);
        x_rd = 0; x_wr = 0; x_err = 1'b0; x_rdata = 32'h0; x_chk = 1'b1;
        if (atop == A_NONE) begin
            if (we) begin
                x_wr = 1; ref_mem[w] = merge(old, be, wd); x_chk = 1'b0;
                if (hit) rsv_v = 1'b0;
            end else begin
                x_rd = 1; x_rdata = old;
            end
        end else if (atop == A_LR && LRSC) begin
            x_rd = 1; x_rdata = old; rsv_v = 1'b1; rsv_a = w;
        end else if (atop == A_SC && LRSC) begin
            if (hit) begin x_wr = 1; ref_mem[w] = wd; x_rdata = 32'h0; end
            else x_rdata = 32'h1;
            rsv_v = 1'b0;
        end else if (atop inside {A_ADD, A_SWAP, A_XOR, A_OR, A_AND, A_MIN, A_MAX, A_MINU, A_MAXU}) begin
            x_rd = 1;
            if (rerr) begin
                x_err = 1'b1; x_chk = 1'b0;
            end else begin
                case (atop)
                    A_ADD:   nv = old + wd;
                    A_SWAP:  nv = wd;
                    A_XOR:   nv = old ^ wd;
                    A_OR:    nv = old | wd;
                    A_AND:   nv = old & wd;
                    A_MIN:   nv = (int'(old) < int'(wd)) ? old : wd;
                    A_MAX:   nv = (int'(old) > int'(wd)) ? old : wd;
                    A_MINU:  nv = (old < wd) ? old : wd;
                    default: nv = (old > wd) ? old : wd;
                endcase
                x_wr = 1; ref_mem[w] = nv; x_rdata = old;
                if (hit) rsv_v = 1'b0;
            end
        end else begin
            x_err = 1'b1; x_rdata = 32'h0;
        end
    endtask

    task automatic do_op(input logic we, input logic [5:0] atop, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output logic ok);
        int n = 0;
        rd = 32'h0; er = 1'b0; ok = 1'b0;
        @(negedge clk);
        sbr_req = 1'b1; sbr_we = we; sbr_atop = atop; sbr_addr = addr; sbr_be = be; sbr_wdata = wd;
        #2;
        forever begin
            if (atop == A_NONE) chk("gnt_follows_mgr", sbr_gnt, mgr_gnt);
            else                chk("amo_gnt_now", sbr_gnt, 1'b1);
            if (sbr_gnt || n >= 50) break;
            @(negedge clk); #2; n++;
        end
        if (!sbr_gnt) begin
            sbr_req = 1'b0; sbr_atop = A_NONE;
            chk("grant_timeout", 1'b0, 1'b1);
            return;
        end
        @(negedge clk);
        sbr_req = 1'b0; sbr_atop = A_NONE; sbr_we = 1'b0;
        #2; n = 0;
        while (!sbr_rvalid && n < 50) begin @(negedge clk); #2; n++; end
        ok = sbr_rvalid; rd = sbr_rdata; er = sbr_err;
        @(negedge clk); #2;
        chk("rvalid_one_cycle", sbr_rvalid, 1'b0);
    endtask

    task automatic run(input string tag, input logic we, input logic [5:0] atop,
                       input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                       input bit rerr, output logic [31:0] rd, output logic er);
        logic [31:0] x_rdata;
        logic        x_err, ok;
        int          x_rd, x_wr;
        bit          x_chk;
        model(we, atop, addr, be, wd, rerr, x_rdata, x_err, x_rd, x_wr, x_chk);
        n_rd = 0; n_wr = 0; req_cycles = 0; inject_rd_err = rerr;
        do_op(we, atop, addr, be, wd, rd, er, ok);
        inject_rd_err = 1'b0;
        chk({tag, "_resp"}, ok, 1'b1);
        chk({tag, "_err"}, er, x_err);
        if (x_chk) chk({tag, "_rdata"}, rd, x_rdata);
        chk({tag, "_nrd"}, n_rd, x_rd);
        chk({tag, "_nwr"}, n_wr, x_wr);
        if (x_rd == 0 && x_wr == 0) chk({tag, "_no_req"}, req_cycles, 0);
        chk({tag, "_mem"}, rd_mem(addr[31:2]), rd_ref(addr[31:2]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [5:0]  ops [14] = '{A_NONE, A_NONE, A_ADD, A_SWAP, A_XOR, A_OR, A_AND, A_MIN,
                                  A_MAX, A_MINU, A_MAXU, A_LR, A_SC, 6'h3F};
        sbr_req = 1'b1; sbr_we = 1'b1; sbr_atop = A_NONE; sbr_addr = 32'h100;
        sbr_be = 4'hF; sbr_wdata = 32'h1; rsv_v = 1'b0; rsv_a = '0; inject_rd_err = 1'b0;
        n_rd = 0; n_wr = 0; req_cycles = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_sbr_gnt", sbr_gnt, 1'b0);
        chk("rst_mgr_req", mgr_req, 1'b0);
        chk("rst_sbr_rvalid", sbr_rvalid, 1'b0);
        chk("rst_no_write", n_wr, 0);
        sbr_req = 1'b0;
        @(negedge clk); rst = 1'b0;

        run("wr100", 1'b1, A_NONE, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0, rd, er);
        run("rd100", 1'b0, A_NONE, 32'h100, 4'hF, 32'h0, 1'b0, rd, er);
        chk("rd100_value", rd, 32'hDEADBEEF);

        run("wr40", 1'b1, A_NONE, 32'h40, 4'hF, 32'd5, 1'b0, rd, er);
        run("add40", 1'b0, A_ADD, 32'h40, 4'h0, 32'd3, 1'b0, rd, er);
        chk("add40_old", rd, 32'd5);
        chk("add40_mem", rd_mem(30'h10), 32'd8);

        run("wr44", 1'b1, A_NONE, 32'h44, 4'hF, 32'hFFFFFFFF, 1'b0, rd, er);
        run("min44", 1'b0, A_MIN, 32'h44, 4'hF, 32'd1, 1'b0, rd, er);
        chk("min44_old", rd, 32'hFFFFFFFF);
        chk("min44_mem", rd_mem(30'h11), 32'hFFFFFFFF);
        run("minu44", 1'b0, A_MINU, 32'h44, 4'hF, 32'd1, 1'b0, rd, er);
        chk("minu44_mem", rd_mem(30'h11), 32'd1);

        run("swap_rderr", 1'b0, A_SWAP, 32'h44, 4'hF, 32'h55, 1'b1, rd, er);
        chk("swap_rderr_flag", er, 1'b1);
        run("illegal3f", 1'b0, 6'h3F, 32'h44, 4'hF, 32'h55, 1'b0, rd, er);
        chk("illegal3f_flag", er, 1'b1);

`ifdef OBI_AMO_SEQ_LRSC_EN
        run("lr80", 1'b0, A_LR, 32'h80, 4'hF, 32'h0, 1'b0, rd, er);
        run("wr80", 1'b1, A_NONE, 32'h80, 4'hF, 32'h77, 1'b0, rd, er);
        run("sc80_fail", 1'b0, A_SC, 32'h80, 4'hF, 32'h99, 1'b0, rd, er);
        chk("sc80_fail_val", rd, 32'h1);
        run("lr80b", 1'b0, A_LR, 32'h80, 4'hF, 32'h0, 1'b0, rd, er);
        run("sc80_ok", 1'b0, A_SC, 32'h80, 4'hF, 32'h99, 1'b0, rd, er);
        chk("sc80_ok_val", rd, 32'h0);
        chk("sc80_ok_mem", rd_mem(30'h20), 32'h99);
`else
        run("lr_disabled", 1'b0, A_LR, 32'h80, 4'hF, 32'h0, 1'b0, rd, er);
        chk("lr_disabled_flag", er, 1'b1);
`endif

        // Reset while an AMO is waiting for its downstream read grant.
        n_wr = 0;
        @(negedge clk);
        sbr_req = 1'b1; sbr_atop = A_ADD; sbr_addr = 32'h40; sbr_wdata = 32'd7;
        #2; chk("midrst_gnt", sbr_gnt, 1'b1);
        @(negedge clk);
        sbr_req = 1'b0; sbr_atop = A_NONE; rst = 1'b1;
        #2; chk("midrst_mgr_req", mgr_req, 1'b0);
        chk("midrst_rvalid", sbr_rvalid, 1'b0);
        @(negedge clk); #2;
        chk("midrst_mgr_req2", mgr_req, 1'b0);
        rst = 1'b0; rsv_v = 1'b0;
        chk("midrst_no_write", n_wr, 0);
        run("after_rst_rd40", 1'b0, A_NONE, 32'h40, 4'hF, 32'h0, 1'b0, rd, er);

        for (int i = 0; i < 60; i++) begin
            logic [5:0]  op   = ops[$urandom_range(0, 13)];
            logic [31:0] addr = {26'h0, 3'($urandom_range(0, 3)), 2'b00} + 32'h200;
            logic        we   = (op == A_NONE) ? 1'($urandom_range(0, 1)) : 1'b0;
            logic [3:0]  be   = (op == A_NONE && we) ? 4'($urandom_range(1, 15)) : 4'hF;
            run($sformatf("rnd%0d", i), we, op, addr, be, $urandom, 1'b0, rd, er);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
